// File: rtl/bsg_cgol_pkg.sv
// Shared types and constants for the Game-of-Life host-side issuer and host link.
package bsg_cgol_pkg;

    localparam int unsigned cycle_width_gp = 32;

    typedef enum logic [1:0] {
        eIDLE,
        eISSUE,
        eWAIT,
        eREPORT
    } issuer_state_e;

    typedef struct packed {
        logic [cycle_width_gp-1:0] games;
        logic [cycle_width_gp-1:0] cycles;
        logic                      timeout;
    } bsg_cgol_stat_s;

    // Widths of 0 or 1 still need a 1-bit field.
    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_cgol_sat_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module bsg_cgol_sat_counter #(
    parameter int unsigned width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {width_p{1'b1}})) begin
            count_d = count_q + width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_cgol_game_issuer.sv
// Issues a batch of games to the CGOL controller and reports games/cycles per batch.
// Define BSG_CGOL_ISSUER_TIMEOUT_EN to abort a batch when a game exceeds timeout_cycles_p.
module bsg_cgol_game_issuer
    import bsg_cgol_pkg::*;
#(
    // max_game_length_p has no meaningful default and must be overridden.
    parameter int unsigned max_game_length_p = 0,
    parameter int unsigned max_repeat_p      = 16,
    parameter int unsigned timeout_cycles_p  = 4096,
    localparam int unsigned game_len_width_lp = safe_clog2(max_game_length_p),
    localparam int unsigned rep_width_lp      = safe_clog2(max_repeat_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [game_len_width_lp-1:0] cmd_frames_i,
    input  logic [rep_width_lp-1:0]      cmd_repeat_i,
    input  logic                         cmd_v_i,
    output logic                         cmd_ready_o,
    output logic [game_len_width_lp-1:0] frames_o,
    output logic                         v_o,
    input  logic                         ready_i,
    input  logic                         done_v_i,
    output logic                         done_yumi_o,
    output logic [rep_width_lp-1:0]      stat_games_o,
    output logic [cycle_width_gp-1:0]    stat_cycles_o,
    output logic                         stat_timeout_o,
    output logic                         stat_v_o,
    input  logic                         stat_yumi_i
);

    issuer_state_e                state_q, state_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic                         v_q, v_d;
    logic                         stat_v_q, stat_v_d;
    logic                         timeout_q, timeout_d;
    logic [game_len_width_lp-1:0] frames_q, frames_d;
    logic [rep_width_lp-1:0]      repeat_q, repeat_d;
    logic [rep_width_lp-1:0]      games_q, games_d;
    logic                         cmd_accept, issue_accept, timeout_hit;
    logic [cycle_width_gp-1:0]    cycles;

    assign cmd_accept   = cmd_ready_q && cmd_v_i;
    assign issue_accept = (state_q == eISSUE) && ready_i;

    bsg_cgol_sat_counter #(
        .width_p(cycle_width_gp)
    ) cycle_counter (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(cmd_accept),
        .en_i   ((state_q == eISSUE) || (state_q == eWAIT)),
        .count_o(cycles)
    );

`ifdef BSG_CGOL_ISSUER_TIMEOUT_EN
    localparam int unsigned wait_width_lp = safe_clog2(timeout_cycles_p);
    logic [wait_width_lp-1:0] wait_cnt;

    bsg_cgol_sat_counter #(
        .width_p(wait_width_lp)
    ) wait_counter (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(cmd_accept || issue_accept),
        .en_i   (state_q == eWAIT),
        .count_o(wait_cnt)
    );

    // Fires on the timeout_cycles_p-th consecutive cycle spent in eWAIT.
    assign timeout_hit = (state_q == eWAIT) && (wait_cnt == wait_width_lp'(timeout_cycles_p - 1));
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = timeout_cycles_p;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        frames_d  = frames_q;
        repeat_d  = repeat_q;
        games_d   = games_q;
        timeout_d = timeout_q;
        unique case (state_q)
            eIDLE: begin
                if (cmd_accept) begin
                    frames_d  = cmd_frames_i;
                    repeat_d  = cmd_repeat_i;
                    games_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = (cmd_repeat_i == '0) ? eREPORT : eISSUE;
                end
            end
            eISSUE: begin
                if (ready_i) begin
                    state_d = eWAIT;
                end
            end
            eWAIT: begin
                if (done_v_i) begin
                    games_d = games_q + rep_width_lp'(1);
                    state_d = (games_d == repeat_q) ? eREPORT : eISSUE;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = eREPORT;
                end
            end
            eREPORT: begin
                if (stat_yumi_i) begin
                    state_d = eIDLE;
                end
            end
            default: state_d = eIDLE;
        endcase
        cmd_ready_d = (state_d == eIDLE);
        v_d         = (state_d == eISSUE);
        stat_v_d    = (state_d == eREPORT);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= eIDLE;
            cmd_ready_q <= 1'b0;
            v_q         <= 1'b0;
            stat_v_q    <= 1'b0;
            timeout_q   <= 1'b0;
            frames_q    <= '0;
            repeat_q    <= '0;
            games_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            v_q         <= v_d;
            stat_v_q    <= stat_v_d;
            timeout_q   <= timeout_d;
            frames_q    <= frames_d;
            repeat_q    <= repeat_d;
            games_q     <= games_d;
        end
    end

    // cmd_ready_q stands in for eIDLE so late completions are not drained while in reset.
    assign done_yumi_o    = done_v_i && ((state_q == eWAIT) || cmd_ready_q);
    assign cmd_ready_o    = cmd_ready_q;
    assign v_o            = v_q;
    assign frames_o       = frames_q;
    assign stat_v_o       = stat_v_q;
    assign stat_games_o   = games_q;
    assign stat_cycles_o  = cycles;
    assign stat_timeout_o = timeout_q;

endmodule
